i2c_txn_arbiter: RTL and testbench

I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

---
 rtl/i2c_arb_pkg.sv | 27 ++
 rtl/i2c_ack_sync.sv | 26 ++
 rtl/i2c_txn_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and default timing constants for the two-requester I2C transaction arbiter.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        MRST,
        START,
        WAIT_ACK,
        STOP,
        RESP
    } arbState_t;

    localparam int START_HOLD = 4;
    localparam int RST_HOLD   = 2;
    localparam int TIMEOUT    = 1023;

    // One counter times every phase, so it must hold the largest limit.
    function automatic int cntWidth(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/i2c_ack_sync.sv
// Brings the master's ack flag into the refresh_clk domain and emits a one-cycle pulse per rising edge.
module i2c_ack_sync
    import i2c_arb_pkg::*;
(
    input  logic refresh_clk,
    input  logic reset,
    input  logic i_ack,
    output logic o_rise
);

    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge refresh_clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_ack};
            r_prev <= r_sync[1];
        end
    end

    assign o_rise = r_sync[1] & ~r_prev;

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that sequences single-byte transactions from two requesters onto one I2C master.
// Optional WAIT_ACK watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int START_HOLD = i2c_arb_pkg::START_HOLD,
    parameter int RST_HOLD   = i2c_arb_pkg::RST_HOLD,
    parameter int TIMEOUT    = i2c_arb_pkg::TIMEOUT
) (
    input  logic       refresh_clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [6:0] req_addr0,
    input  logic [6:0] req_addr1,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    input  logic [1:0] req_rw,
    output logic [1:0] grant,
    output logic [1:0] rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    output logic       m_rst_n,
    output logic       m_en,
    output logic       m_start,
    output logic       m_stop,
    output logic       m_repeat_start,
    output logic       m_mode,
    output logic [6:0] m_address,
    output logic [7:0] m_register,
    input  logic [7:0] m_out,
    input  logic       m_ack
);

    localparam int                CNT_W      = cntWidth(START_HOLD, RST_HOLD, TIMEOUT);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_HOLD - 1);
`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
`endif

    arbState_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ackSeen;
    logic             r_lastGrant;
    logic [1:0]       r_grant;
    logic [1:0]       r_rspValid;
    logic [7:0]       r_rspData;
    logic             r_busy;
    logic             r_mRstN;
    logic             r_mEn;
    logic             r_mStart;
    logic             r_mStop;
    logic             r_mMode;
    logic [6:0]       r_address;
    logic [7:0]       r_register;
`ifdef I2C_ARB_TIMEOUT_EN
    logic             r_rspErr;
`endif

    logic w_ackRise;
    logic w_pick1;

    i2c_ack_sync u_ackSync (
        .refresh_clk (refresh_clk),
        .reset       (reset),
        .i_ack       (m_ack),
        .o_rise      (w_ackRise)
    );

    // Requester 1 wins when it is the only one asking, or when both ask and 0 went last.
    assign w_pick1 = req_valid[1] & (~req_valid[0] | ~r_lastGrant);

    always_ff @(posedge refresh_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ackSeen   <= 1'b0;
            r_lastGrant <= 1'b1;
            r_grant     <= 2'b00;
            r_rspValid  <= 2'b00;
            r_rspData   <= 8'h00;
            r_busy      <= 1'b0;
            r_mRstN     <= 1'b0;
            r_mEn       <= 1'b0;
            r_mStart    <= 1'b0;
            r_mStop     <= 1'b0;
            r_mMode     <= 1'b0;
            r_address   <= 7'h00;
            r_register  <= 8'h00;
`ifdef I2C_ARB_TIMEOUT_EN
            r_rspErr    <= 1'b0;
`endif
        end else begin
            r_rspValid <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_state <= ARB;
                        r_busy  <= 1'b1;
                    end
                end
                ARB: begin
                    r_cnt     <= '0;
                    r_ackSeen <= 1'b0;
                    if (|req_valid) begin
                        r_grant    <= w_pick1 ? 2'b10 : 2'b01;
                        r_address  <= w_pick1 ? req_addr1 : req_addr0;
                        r_register <= w_pick1 ? req_data1 : req_data0;
                        r_mMode    <= w_pick1 ? req_rw[1] : req_rw[0];
                        r_mRstN    <= 1'b0;
                        r_state    <= MRST;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                MRST: begin
                    if (r_cnt == RST_LAST) begin
                        r_cnt    <= '0;
                        r_mRstN  <= 1'b1;
                        r_mEn    <= 1'b1;
                        r_mStart <= 1'b1;
                        r_mStop  <= 1'b1;
                        r_state  <= START;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == START_LAST) begin
                        r_cnt    <= '0;
                        r_mStart <= 1'b0;
                        r_state  <= WAIT_ACK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // First ack edge is the address phase, the second closes the data byte.
                WAIT_ACK: begin
                    if (w_ackRise && r_ackSeen) begin
                        r_mEn   <= 1'b0;
                        r_state <= STOP;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (r_cnt == TIMEOUT_LAST) begin
                        r_mEn    <= 1'b0;
                        r_rspErr <= 1'b1;
                        r_state  <= STOP;
                    end
`endif
                    else if (w_ackRise) begin
                        r_ackSeen <= 1'b1;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    r_cnt <= r_cnt + 1'b1;
`endif
                end
                STOP: begin
                    r_mStop    <= 1'b0;
                    r_rspValid <= r_grant;
`ifdef I2C_ARB_TIMEOUT_EN
                    r_rspData  <= (r_mMode && !r_rspErr) ? m_out : 8'h00;
`else
                    r_rspData  <= r_mMode ? m_out : 8'h00;
`endif
                    r_state    <= RESP;
                end
                RESP: begin
                    r_lastGrant <= r_grant[1];
                    r_grant     <= 2'b00;
                    r_busy      <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
                    r_rspErr    <= 1'b0;
`endif
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant          = r_grant;
    assign rsp_valid      = r_rspValid;
    assign rsp_data       = r_rspData;
    assign busy           = r_busy;
    assign m_rst_n        = r_mRstN;
    assign m_en           = r_mEn;
    assign m_start        = r_mStart;
    assign m_stop         = r_mStop;
    assign m_repeat_start = 1'b0;
    assign m_mode         = r_mMode;
    assign m_address      = r_address;
    assign m_register     = r_register;
`ifdef I2C_ARB_TIMEOUT_EN
    assign rsp_err        = r_rspErr;
`else
    assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: a simple master model answers with ack pulses and read bytes.
module tb_i2c_txn_arbiter;

    localparam int START_HOLD = 4;
    localparam int RST_HOLD   = 2;
    localparam int TIMEOUT    = 1023;

    typedef struct packed {
        logic [1:0] who;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    logic       refresh_clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [6:0] req_addr0, req_addr1;
    logic [7:0] req_data0, req_data1;
    logic [1:0] req_rw;
    logic [1:0] grant, rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err, busy;
    logic       m_rst_n, m_en, m_start, m_stop, m_repeat_start, m_mode;
    logic [6:0] m_address;
    logic [7:0] m_register;
    logic [7:0] m_out;
    logic       m_ack;

    int   checkCount = 0;
    int   passCount  = 0;
    int   cycCount   = 0;
    int   waitEntry  = 0;
    rsp_t expQ[$];

    i2c_txn_arbiter #(
        .START_HOLD (START_HOLD),
        .RST_HOLD   (RST_HOLD),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .refresh_clk    (refresh_clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr0      (req_addr0),
        .req_addr1      (req_addr1),
        .req_data0      (req_data0),
        .req_data1      (req_data1),
        .req_rw         (req_rw),
        .grant          (grant),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .m_rst_n        (m_rst_n),
        .m_en           (m_en),
        .m_start        (m_start),
        .m_stop         (m_stop),
        .m_repeat_start (m_repeat_start),
        .m_mode         (m_mode),
        .m_address      (m_address),
        .m_register     (m_register),
        .m_out          (m_out),
        .m_ack          (m_ack)
    );

    always #5 refresh_clk = ~refresh_clk;

    always @(posedge refresh_clk) cycCount <= cycCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [6:0] a0, input logic [7:0] d0,
                                 input logic [6:0] a1, input logic [7:0] d1, input logic [1:0] rw);
        req_valid = valid;
        req_addr0 = a0;
        req_data0 = d0;
        req_addr1 = a1;
        req_data1 = d1;
        req_rw    = rw;
    endtask

    task automatic pulseAck();
        m_ack = 1'b1;
        repeat (3) @(negedge refresh_clk);
        m_ack = 1'b0;
        repeat (3) @(negedge refresh_clk);
    endtask

    task automatic waitGrant(input logic [1:0] want, input string tag);
        int guard = 0;
        while (grant === 2'b00 && guard < 50) begin
            @(negedge refresh_clk);
            guard++;
        end
        checkOutput(tag, grant, want);
    endtask

    task automatic waitIdle(input int limit);
        int guard = 0;
        while (busy !== 1'b0 && guard < limit) begin
            @(negedge refresh_clk);
            guard++;
        end
        checkOutput("idleReached", busy, 0);
        checkOutput("sbDrained", expQ.size(), 0);
    endtask

    // Called on the negedge where the grant first shows; walks the reset and start phases, then acks.
    task automatic serveMaster(input int nEdges, input logic [7:0] rdByte);
        int rstLow    = 0;
        int startHigh = 0;
        int guard     = 0;
        m_out = rdByte;
        while (m_rst_n === 1'b0 && guard < 100) begin
            rstLow++;
            guard++;
            @(negedge refresh_clk);
        end
        checkOutput("rstHold", rstLow, RST_HOLD);
        checkOutput("ctrlAtStart", {m_en, m_start, m_stop, m_repeat_start}, 4'b1110);
        while (m_start === 1'b1 && guard < 100) begin
            startHigh++;
            guard++;
            @(negedge refresh_clk);
        end
        checkOutput("startHold", startHigh, START_HOLD);
        waitEntry = cycCount;
        for (int i = 0; i < nEdges; i++) pulseAck();
    endtask

    always @(negedge refresh_clk) begin : rspMonitor
        rsp_t e;
        if (rsp_valid !== 2'b00) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRsp", rsp_valid, 2'b00);
            end else begin
                e = expQ.pop_front();
                checkOutput("rspWho", rsp_valid, e.who);
                checkOutput("rspData", rsp_data, e.data);
                checkOutput("rspErr", rsp_err, e.err);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: got running, want finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [1:0] want;
        logic [7:0] rdByte;
        int         guard;
        reset = 1'b0;
        m_ack = 1'b0;
        m_out = 8'h00;
        applyStimulus(2'b00, 7'h00, 8'h00, 7'h00, 8'h00, 2'b00);
        repeat (3) @(negedge refresh_clk);
        checkOutput("rstGrant", grant, 0);
        checkOutput("rstRsp", {rsp_valid, rsp_data, rsp_err}, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstMctl", {m_rst_n, m_en, m_start, m_stop, m_repeat_start, m_mode}, 0);
        checkOutput("rstMaddr", {m_address, m_register}, 0);
        reset = 1'b1;
        @(negedge refresh_clk);

        // Requester 0 write, slave acks address and data.
        applyStimulus(2'b01, 7'h50, 8'hA5, 7'h00, 8'h00, 2'b00);
        expQ.push_back(rsp_t'{2'b01, 8'h00, 1'b0});
        waitGrant(2'b01, "t1Grant");
        checkOutput("t1Addr", m_address, 7'h50);
        checkOutput("t1Data", m_register, 8'hA5);
        checkOutput("t1Mode", m_mode, 0);
        checkOutput("t1Busy", busy, 1);
        req_valid = 2'b00;
        serveMaster(2, 8'hFF);
        waitIdle(50);

        // Requester 1 read returns the master's byte.
        applyStimulus(2'b10, 7'h00, 8'h00, 7'h3C, 8'h00, 2'b10);
        expQ.push_back(rsp_t'{2'b10, 8'h7E, 1'b0});
        waitGrant(2'b10, "t2Grant");
        checkOutput("t2Addr", m_address, 7'h3C);
        checkOutput("t2Mode", m_mode, 1);
        req_valid = 2'b00;
        serveMaster(2, 8'h7E);
        waitIdle(50);

        // Both requesters held valid from reset: grants must alternate starting with 0.
        reset = 1'b0;
        @(negedge refresh_clk);
        reset = 1'b1;
        @(negedge refresh_clk);
        applyStimulus(2'b11, 7'h21, 8'h5A, 7'h42, 8'h00, 2'b10);
        for (int k = 0; k < 4; k++) begin
            want   = (k % 2 == 0) ? 2'b01 : 2'b10;
            rdByte = 8'hC0 + 8'(k);
            expQ.push_back(rsp_t'{want, (want == 2'b10) ? rdByte : 8'h00, 1'b0});
            waitGrant(want, "t3Grant");
            checkOutput("t3Addr", m_address, (want == 2'b01) ? 7'h21 : 7'h42);
            if (k == 3) req_valid = 2'b00;
            serveMaster(2, rdByte);
            guard = 0;
            while (grant !== 2'b00 && guard < 50) begin
                @(negedge refresh_clk);
                guard++;
            end
        end
        waitIdle(50);

        // A stray ack while idle must not count toward the next transaction.
        pulseAck();
        applyStimulus(2'b01, 7'h33, 8'h66, 7'h00, 8'h00, 2'b00);
        expQ.push_back(rsp_t'{2'b01, 8'h00, 1'b0});
        waitGrant(2'b01, "t4Grant");
        req_valid = 2'b00;
        serveMaster(1, 8'h00);
        repeat (10) @(negedge refresh_clk);
        checkOutput("t4StillBusy", busy, 1);
        checkOutput("t4Pending", expQ.size(), 1);
        pulseAck();
        waitIdle(50);

        // Address NACK: only one ack edge ever arrives.
        applyStimulus(2'b01, 7'h11, 8'h00, 7'h00, 8'h00, 2'b01);
        waitGrant(2'b01, "t5Grant");
        checkOutput("t5Addr", m_address, 7'h11);
        req_valid = 2'b00;
`ifdef I2C_ARB_TIMEOUT_EN
        expQ.push_back(rsp_t'{2'b01, 8'h00, 1'b1});
        serveMaster(1, 8'hAB);
        guard = 0;
        while (rsp_err !== 1'b1 && guard < TIMEOUT + 100) begin
            @(negedge refresh_clk);
            guard++;
        end
        checkOutput("t5ErrDelay", cycCount - waitEntry, TIMEOUT);
        waitIdle(50);
`else
        serveMaster(1, 8'hAB);
        repeat (200) @(negedge refresh_clk);
        checkOutput("t5Hang", busy, 1);
        checkOutput("t5NoErr", rsp_err, 0);
        checkOutput("t5GrantHeld", grant, 2'b01);
        reset = 1'b0;
        @(negedge refresh_clk);
        reset = 1'b1;
        @(negedge refresh_clk);
`endif

        // Reset in the middle of WAIT_ACK abandons the transaction silently.
        applyStimulus(2'b10, 7'h00, 8'h00, 7'h2A, 8'h99, 2'b00);
        waitGrant(2'b10, "t6Grant");
        req_valid = 2'b00;
        serveMaster(1, 8'h00);
        checkOutput("t6BusyBefore", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6Grant0", grant, 0);
        checkOutput("t6Busy0", busy, 0);
        checkOutput("t6Mctl", {m_rst_n, m_en, m_start, m_stop, m_repeat_start, m_mode}, 0);
        checkOutput("t6Maddr", {m_address, m_register}, 0);
        checkOutput("t6Rsp", {rsp_valid, rsp_data, rsp_err}, 0);
        @(negedge refresh_clk);
        reset = 1'b1;
        repeat (10) @(negedge refresh_clk);
        checkOutput("t6StaysIdle", busy, 0);

        repeat (5) @(negedge refresh_clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
